// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: consumer end of the EX/MEM pipeline register.
// Runs a req/ack data-memory transaction for loads and stores, stalls the
// upstream stages while it is outstanding, and writes registered MEM/WB fields.
// Non-memory instructions pass straight through to MEM/WB in one cycle.
module mem_stage_ctrl #(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 16,
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ex_valid,
  input  logic              i_mem_to_reg,
  input  logic              i_mem_write,
  input  logic [PC_W-1:0]   i_pc_count,
  input  logic [DATA_W-1:0] i_rd2,
  input  logic [DATA_W-1:0] i_alu_result,
  output logic              o_stall,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [DATA_W-1:0] o_dmem_wdata,
  input  logic              i_dmem_ack,
  input  logic [DATA_W-1:0] i_dmem_rdata,
  output logic              o_wb_valid,
  output logic              o_wb_mem_to_reg,
  output logic [PC_W-1:0]   o_wb_pc_count,
  output logic [DATA_W-1:0] o_wb_read_data,
  output logic [DATA_W-1:0] o_wb_alu_result,
  output logic              o_err_misaligned,
  output logic              o_err_timeout
);

  // The wait counter only needs to reach TIMEOUT-1; keep at least one bit.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_load;
  logic [PC_W-1:0]     r_pc;
  logic [DATA_W-1:0]   r_alu;
  logic                r_dmem_req;
  logic                r_dmem_we;
  logic [ADDR_W-1:0]   r_dmem_addr;
  logic [DATA_W-1:0]   r_dmem_wdata;
  logic                r_wb_valid;
  logic                r_wb_mem_to_reg;
  logic [PC_W-1:0]     r_wb_pc_count;
  logic [DATA_W-1:0]   r_wb_read_data;
  logic [DATA_W-1:0]   r_wb_alu_result;
  logic                r_err_misaligned;
  logic                r_err_timeout;

  logic w_memop;
  logic w_misaligned;
  logic w_accept;
  logic w_cnt_last;
  logic w_busy_wait;

  // A store wins when both flags are set, so only mem_write decides direction.
  assign w_memop      = i_ex_valid & (i_mem_to_reg | i_mem_write);
  assign w_misaligned = (i_alu_result[1:0] != 2'b00);
  assign w_accept     = (r_state == S_IDLE) & w_memop & ~w_misaligned;
  assign w_cnt_last   = (r_cnt == CNT_LAST);
  assign w_busy_wait  = (r_state == S_BUSY) & ~i_dmem_ack & ~w_cnt_last;

  // Stall is forced low during reset so every output reads 0 while held.
  assign o_stall = i_rst_n & (w_accept | w_busy_wait);

  assign o_dmem_req       = r_dmem_req;
  assign o_dmem_we        = r_dmem_we;
  assign o_dmem_addr      = r_dmem_addr;
  assign o_dmem_wdata     = r_dmem_wdata;
  assign o_wb_valid       = r_wb_valid;
  assign o_wb_mem_to_reg  = r_wb_mem_to_reg;
  assign o_wb_pc_count    = r_wb_pc_count;
  assign o_wb_read_data   = r_wb_read_data;
  assign o_wb_alu_result  = r_wb_alu_result;
  assign o_err_misaligned = r_err_misaligned;
  assign o_err_timeout    = r_err_timeout;

  // Transaction FSM with registered memory-side and MEM/WB outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_load           <= 1'b0;
      r_pc             <= '0;
      r_alu            <= '0;
      r_dmem_req       <= 1'b0;
      r_dmem_we        <= 1'b0;
      r_dmem_addr      <= '0;
      r_dmem_wdata     <= '0;
      r_wb_valid       <= 1'b0;
      r_wb_mem_to_reg  <= 1'b0;
      r_wb_pc_count    <= '0;
      r_wb_read_data   <= '0;
      r_wb_alu_result  <= '0;
      r_err_misaligned <= 1'b0;
      r_err_timeout    <= 1'b0;
    end else begin
      r_err_misaligned <= 1'b0;
      r_err_timeout    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!i_ex_valid) begin
            r_wb_valid <= 1'b0;
          end else if (!w_memop) begin
            r_wb_valid      <= 1'b1;
            r_wb_mem_to_reg <= i_mem_to_reg;
            r_wb_pc_count   <= i_pc_count;
            r_wb_read_data  <= '0;
            r_wb_alu_result <= i_alu_result;
          end else if (w_misaligned) begin
            r_wb_valid       <= 1'b0;
            r_err_misaligned <= 1'b1;
          end else begin
            r_dmem_req   <= 1'b1;
            r_dmem_we    <= i_mem_write;
            r_dmem_addr  <= i_alu_result[ADDR_W+1:2];
            r_dmem_wdata <= i_rd2;
            r_load       <= i_mem_to_reg & ~i_mem_write;
            r_pc         <= i_pc_count;
            r_alu        <= i_alu_result;
            r_cnt        <= '0;
            r_wb_valid   <= 1'b0;
            r_state      <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (i_dmem_ack) begin
            r_dmem_req      <= 1'b0;
            r_wb_valid      <= 1'b1;
            r_wb_mem_to_reg <= r_load;
            r_wb_read_data  <= r_load ? i_dmem_rdata : '0;
            r_wb_pc_count   <= r_pc;
            r_wb_alu_result <= r_alu;
            r_state         <= S_IDLE;
          end else if (w_cnt_last) begin
            r_dmem_req    <= 1'b0;
            r_err_timeout <= 1'b1;
            r_wb_valid    <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_cnt      <= r_cnt + CNT_W'(1);
            r_wb_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed stimulus with a queue-based scoreboard.
// Stimulus pushes the expected MEM/WB or error event; a monitor pops and
// compares whenever the DUT presents wb_valid or an error pulse.
module tb_mem_stage_ctrl;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_ex_valid;
  logic        i_mem_to_reg;
  logic        i_mem_write;
  logic [15:0] i_pc_count;
  logic [31:0] i_rd2;
  logic [31:0] i_alu_result;
  logic        o_stall;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [13:0] o_dmem_addr;
  logic [31:0] o_dmem_wdata;
  logic        i_dmem_ack;
  logic [31:0] i_dmem_rdata;
  logic        o_wb_valid;
  logic        o_wb_mem_to_reg;
  logic [15:0] o_wb_pc_count;
  logic [31:0] o_wb_read_data;
  logic [31:0] o_wb_alu_result;
  logic        o_err_misaligned;
  logic        o_err_timeout;

  typedef struct {
    logic        isWb;
    logic        isMis;
    logic        isTo;
    logic        mtr;
    logic [15:0] pc;
    logic [31:0] rd;
    logic [31:0] alu;
  } exp_t;

  exp_t expQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;

  mem_stage_ctrl #(
    .DATA_W (32),
    .PC_W   (16),
    .ADDR_W (14),
    .TIMEOUT(4)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_ex_valid      (i_ex_valid),
    .i_mem_to_reg    (i_mem_to_reg),
    .i_mem_write     (i_mem_write),
    .i_pc_count      (i_pc_count),
    .i_rd2           (i_rd2),
    .i_alu_result    (i_alu_result),
    .o_stall         (o_stall),
    .o_dmem_req      (o_dmem_req),
    .o_dmem_we       (o_dmem_we),
    .o_dmem_addr     (o_dmem_addr),
    .o_dmem_wdata    (o_dmem_wdata),
    .i_dmem_ack      (i_dmem_ack),
    .i_dmem_rdata    (i_dmem_rdata),
    .o_wb_valid      (o_wb_valid),
    .o_wb_mem_to_reg (o_wb_mem_to_reg),
    .o_wb_pc_count   (o_wb_pc_count),
    .o_wb_read_data  (o_wb_read_data),
    .o_wb_alu_result (o_wb_alu_result),
    .o_err_misaligned(o_err_misaligned),
    .o_err_timeout   (o_err_timeout)
  );

  // 10-unit clock period.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Hard stop in case something never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic ld, input logic st,
                               input logic [15:0] pc, input logic [31:0] rd2, input logic [31:0] alu);
    i_ex_valid   = valid;
    i_mem_to_reg = ld;
    i_mem_write  = st;
    i_pc_count   = pc;
    i_rd2        = rd2;
    i_alu_result = alu;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic expectWb(input logic mtr, input logic [15:0] pc, input logic [31:0] rd, input logic [31:0] alu);
    exp_t e;
    e.isWb = 1'b1; e.isMis = 1'b0; e.isTo = 1'b0;
    e.mtr = mtr; e.pc = pc; e.rd = rd; e.alu = alu;
    expQ.push_back(e);
  endtask

  task automatic expectErr(input logic mis, input logic to);
    exp_t e;
    e.isWb = 1'b0; e.isMis = mis; e.isTo = to;
    e.mtr = 1'b0; e.pc = '0; e.rd = '0; e.alu = '0;
    expQ.push_back(e);
  endtask

  // Runs an already-driven aligned mem op: ack arrives after ackDelay BUSY cycles.
  task automatic runMemOp(input int ackDelay, input int expStall, input logic [13:0] expAddr,
                          input logic expWe, input logic [31:0] expWdata, input logic [31:0] rdata,
                          input string name);
    int stallCnt = 0;
    @(negedge i_clk);
    checkOutput({name, "_req_before_accept"}, 64'(o_dmem_req), 64'd0);
    stallCnt += int'(o_stall);
    tick();
    for (int i = 0; i <= ackDelay; i++) begin
      if (i == ackDelay) begin
        i_dmem_ack   = 1'b1;
        i_dmem_rdata = rdata;
      end
      @(negedge i_clk);
      if (i == 0) begin
        checkOutput({name, "_addr"}, 64'(o_dmem_addr), 64'(expAddr));
        checkOutput({name, "_we"}, 64'(o_dmem_we), 64'(expWe));
        checkOutput({name, "_wdata"}, 64'(o_dmem_wdata), 64'(expWdata));
      end
      checkOutput({name, "_req_held"}, 64'(o_dmem_req), 64'd1);
      stallCnt += int'(o_stall);
      tick();
    end
    i_dmem_ack   = 1'b0;
    i_dmem_rdata = 32'h0BAD_0BAD;
    checkOutput({name, "_stall_cycles"}, 64'(stallCnt), 64'(expStall));
  endtask

  // Monitor: every presented MEM/WB result or error pulse must match the queue head.
  always @(negedge i_clk) begin
    if (i_rst_n && (o_wb_valid || o_err_misaligned || o_err_timeout)) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_output", 64'({o_wb_valid, o_err_misaligned, o_err_timeout}), 64'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("event_kind", 64'({o_wb_valid, o_err_misaligned, o_err_timeout}),
                    64'({e.isWb, e.isMis, e.isTo}));
        if (e.isWb) begin
          checkOutput("wb_mem_to_reg", 64'(o_wb_mem_to_reg), 64'(e.mtr));
          checkOutput("wb_pc_count", 64'(o_wb_pc_count), 64'(e.pc));
          checkOutput("wb_read_data", 64'(o_wb_read_data), 64'(e.rd));
          checkOutput("wb_alu_result", 64'(o_wb_alu_result), 64'(e.alu));
        end
      end
    end
  end

  initial begin
    i_rst_n      = 1'b0;
    i_dmem_ack   = 1'b0;
    i_dmem_rdata = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0);

    // Reset held with random inputs: every output stays 0.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    16'($urandom), $urandom, $urandom & 32'hFFFF_FFFC);
      i_dmem_ack   = 1'($urandom_range(0, 1));
      i_dmem_rdata = $urandom;
      @(negedge i_clk);
      checkOutput("reset_ctrl", 64'({o_stall, o_dmem_req, o_dmem_we, o_wb_valid, o_wb_mem_to_reg,
                                     o_err_misaligned, o_err_timeout}), 64'd0);
      checkOutput("reset_addr", 64'(o_dmem_addr), 64'd0);
      checkOutput("reset_wdata", 64'(o_dmem_wdata), 64'd0);
      checkOutput("reset_wb_pc", 64'(o_wb_pc_count), 64'd0);
      checkOutput("reset_wb_rd", 64'(o_wb_read_data), 64'd0);
      checkOutput("reset_wb_alu", 64'(o_wb_alu_result), 64'd0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0);
    i_dmem_ack = 1'b0;
    i_rst_n    = 1'b1;
    tick();

    // ALU op passes through in one cycle with no stall.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0010, 32'h7777_7777, 32'h0000_1234);
    expectWb(1'b0, 16'h0010, 32'h0, 32'h0000_1234);
    @(negedge i_clk);
    checkOutput("alu_stall", 64'(o_stall), 64'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0);
    @(negedge i_clk);
    checkOutput("alu_no_req", 64'(o_dmem_req), 64'd0);
    tick();

    // Load with ack three BUSY cycles after the request.
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0020, 32'h1111_1111, 32'h0000_0040);
    expectWb(1'b1, 16'h0020, 32'hDEAD_BEEF, 32'h0000_0040);
    runMemOp(3, 4, 14'h10, 1'b0, 32'h1111_1111, 32'hDEAD_BEEF, "load");
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0);
    tick();

    // Store acked in the first BUSY cycle; read data must not leak through.
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0024, 32'hCAFE_F00D, 32'h0000_0008);
    expectWb(1'b0, 16'h0024, 32'h0, 32'h0000_0008);
    runMemOp(0, 1, 14'h2, 1'b1, 32'hCAFE_F00D, 32'h5555_5555, "store");
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0);
    tick();

    // Misaligned load: error pulse only, no request, no stall.
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0028, 32'h0, 32'h0000_0006);
    expectErr(1'b1, 1'b0);
    @(negedge i_clk);
    checkOutput("misaligned_stall", 64'(o_stall), 64'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0);
    @(negedge i_clk);
    checkOutput("misaligned_no_req", 64'(o_dmem_req), 64'd0);
    tick();

    // Ack while idle is ignored.
    i_dmem_ack   = 1'b1;
    i_dmem_rdata = 32'h9999_9999;
    tick();
    i_dmem_ack = 1'b0;
    @(negedge i_clk);
    checkOutput("idle_ack_ignored", 64'({o_dmem_req, o_wb_valid}), 64'd0);
    tick();

    // Timeout: request held for TIMEOUT cycles, stall released on the last.
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0030, 32'hA5A5_A5A5, 32'h0000_0100);
    expectErr(1'b0, 1'b1);
    @(negedge i_clk);
    checkOutput("timeout_accept_stall", 64'(o_stall), 64'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      checkOutput("timeout_req_held", 64'(o_dmem_req), 64'd1);
      checkOutput("timeout_stall", 64'(o_stall), (i < 3) ? 64'd1 : 64'd0);
      tick();
    end

    // Next op is accepted the cycle right after the abort.
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0040, 32'h0, 32'h0000_000C);
    expectWb(1'b1, 16'h0040, 32'h0123_4567, 32'h0000_000C);
    runMemOp(1, 2, 14'h3, 1'b0, 32'h0, 32'h0123_4567, "after_timeout");

    // Back-to-back store with no idle gap; both flags set means store.
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0044, 32'h1234_5678, 32'h0000_0014);
    expectWb(1'b0, 16'h0044, 32'h0, 32'h0000_0014);
    runMemOp(0, 1, 14'h5, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF, "b2b_store");
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0);
    tick();

    // Reset mid-BUSY drops the request immediately.
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0050, 32'h0, 32'h0000_0080);
    tick();
    #2;
    i_rst_n = 1'b0;
    #1;
    checkOutput("midbusy_reset_req", 64'(o_dmem_req), 64'd0);
    checkOutput("midbusy_reset_stall", 64'(o_stall), 64'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0);
    i_rst_n = 1'b1;
    tick();

    // After reset the FSM is idle: an ALU op completes in one cycle.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0060, 32'h0, 32'h0000_BEEF);
    expectWb(1'b0, 16'h0060, 32'h0, 32'h0000_BEEF);
    @(negedge i_clk);
    checkOutput("post_reset_stall", 64'(o_stall), 64'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0);
    repeat (3) tick();

    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
